// File: rtl/window_scan_ctrl_if.sv
// rtl/window_scan_ctrl_if.sv - image RAM read and window handshake bundle for window_scan_ctrl
interface window_scan_ctrl_if #(
  parameter int ADDR_W = 21
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd_en;
  logic              shift_en;
  logic              win_valid;
  logic [15:0]       win_row;
  logic [15:0]       win_col;
  logic              out_ready;

  // Sequencer side: drives RAM reads, chain shift and window tags.
  modport master (
    output ram_addr,
    output ram_rd_en,
    output shift_en,
    output win_valid,
    output win_row,
    output win_col,
    input  out_ready
  );

  // Consumer side: RAM, line-buffer chain and downstream filter.
  modport slave (
    input  ram_addr,
    input  ram_rd_en,
    input  shift_en,
    input  win_valid,
    input  win_row,
    input  win_col,
    output out_ready
  );
endinterface

// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - raster frame sequencer for the WINxWIN line-buffer window generator
module window_scan_ctrl #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int WIN    = 11,
  parameter int ADDR_W = 21
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  window_scan_ctrl_if.master        bus,
  output logic                      busy,
  output logic                      done
);

  localparam int                HALF      = (WIN - 1) / 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [15:0]       COL_LAST  = 16'(IMG_W - 1);
  localparam logic [15:0]       ROW_LAST  = 16'(IMG_H - 1);
  localparam logic [15:0]       EDGE      = 16'(WIN - 1);
  localparam logic [15:0]       HALF16    = 16'(HALF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] rd_addr;
  logic              pend;
  logic [15:0]       pix_row;
  logic [15:0]       pix_col;

  logic              win_valid_q;
  logic [15:0]       win_row_q;
  logic [15:0]       win_col_q;

  logic              stall;
  logic              shift;
  logic              rd_en;
  logic              accept;
  logic              last_rd;
  logic              frame_go;
  logic              last_pix;

  // Handshake decode: a pending pixel advances unless the presented window is stalled,
  // and a new read is only issued when the single in-flight slot is free or draining now.
  always_comb begin
    stall    = win_valid_q & ~bus.out_ready;
    shift    = pend & ~stall;
    rd_en    = (state == ST_SCAN) & (~pend | shift);
    accept   = win_valid_q & bus.out_ready;
    last_rd  = rd_en & (rd_addr == LAST_ADDR);
    frame_go = (state == ST_IDLE) & start;
    last_pix = (pix_row == ROW_LAST) & (pix_col == COL_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs; DRAIN waits for the last pixel and its window to leave.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (last_rd) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!pend && (!win_valid_q || bus.out_ready)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read address and in-flight flag; the address saturates at the last pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
      pend    <= 1'b0;
    end else if (frame_go) begin
      rd_addr <= '0;
      pend    <= 1'b0;
    end else begin
      if (rd_en && (rd_addr != LAST_ADDR)) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
      pend <= rd_en | (pend & ~shift);
    end
  end

  // Raster position of the pixel that enters the chain on the next shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_row <= '0;
      pix_col <= '0;
    end else if (frame_go) begin
      pix_row <= '0;
      pix_col <= '0;
    end else if (shift && !last_pix) begin
      if (pix_col == COL_LAST) begin
        pix_col <= '0;
        pix_row <= pix_row + 16'd1;
      end else begin
        pix_col <= pix_col + 16'd1;
      end
    end
  end

  // Window tag: a shift presents the window whose bottom-right corner is the new pixel;
  // otherwise an accepted window retires and an unaccepted one holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else if (shift) begin
      win_valid_q <= (pix_row >= EDGE) && (pix_col >= EDGE);
      win_row_q   <= pix_row - HALF16;
      win_col_q   <= pix_col - HALF16;
    end else if (accept) begin
      win_valid_q <= 1'b0;
    end
  end

  assign bus.ram_addr  = rd_addr;
  assign bus.ram_rd_en = rd_en;
  assign bus.shift_en  = shift;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// tb/tb_window_scan_ctrl.sv - randomized scoreboard bench for window_scan_ctrl
module tb_window_scan_ctrl;

  localparam int IMG_W  = 16;
  localparam int IMG_H  = 12;
  localparam int WIN    = 11;
  localparam int ADDR_W = 8;
  localparam int HALF   = (WIN - 1) / 2;
  localparam int N      = IMG_W * IMG_H;
  localparam int NWIN   = (IMG_W - WIN + 1) * (IMG_H - WIN + 1);

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] dout  = 8'd0;

  window_scan_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  window_scan_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Image RAM whose word at address a is a; 1-cycle read, dout holds when not read.
  always @(posedge clk) begin
    if (bus.ram_rd_en) dout <= bus.ram_addr;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit in_image(input int k);
    return ((k / IMG_W) >= WIN - 1) && ((k % IMG_W) >= WIN - 1);
  endfunction

  int exp_r[$];
  int exp_c[$];

  // Reference model: frame phase plus counts of reads, shifts and accepted windows.
  int m_phase    = 0;
  int m_reads    = 0;
  int m_shifts   = 0;
  int m_acc      = 0;
  int m_done_cnt = 0;
  bit ev         = 0;
  int er         = 0;
  int ec         = 0;
  bit rst_prev   = 0;

  always @(negedge clk) begin
    int inflight;
    int k;
    bit stl;
    bit exp_sh;
    bit exp_rd;
    bit acc_now;
    bit fin;
    exp_sh  = 0;
    exp_rd  = 0;
    acc_now = 0;
    inflight = 0;
    if (rst_prev) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_rd_en", bus.ram_rd_en, 0);
      chk("rst_shift_en", bus.shift_en, 0);
      chk("rst_win_valid", bus.win_valid, 0);
      chk("rst_win_row", bus.win_row, 0);
      chk("rst_win_col", bus.win_col, 0);
      m_phase  = 0;
      m_reads  = 0;
      m_shifts = 0;
      m_acc    = 0;
      ev       = 0;
    end else begin
      inflight = m_reads - m_shifts;
      stl      = ev && !bus.out_ready;
      exp_sh   = (m_phase == 1) && (inflight == 1) && !stl;
      exp_rd   = (m_phase == 1) && (m_reads < N) && (inflight == 0 || exp_sh);
      acc_now  = ev && bus.out_ready;
      chk("busy", busy, int'(m_phase == 1));
      chk("done", done, int'(m_phase == 2));
      chk("shift_en", bus.shift_en, int'(exp_sh));
      chk("ram_rd_en", bus.ram_rd_en, int'(exp_rd));
      chk("win_valid", bus.win_valid, int'(ev));
      if (ev) begin
        chk("win_row", bus.win_row, er);
        chk("win_col", bus.win_col, ec);
      end
      if (bus.ram_rd_en) chk("ram_addr", bus.ram_addr, m_reads);
      if (bus.shift_en) chk("pixel", dout, m_shifts % 256);
      if (bus.win_valid && bus.out_ready) begin
        chk("window_in_range", int'(m_acc < NWIN), 1);
        if (m_acc < NWIN) begin
          chk("centre_row", bus.win_row, exp_r[m_acc]);
          chk("centre_col", bus.win_col, exp_c[m_acc]);
        end
        m_acc++;
      end
      if (done) m_done_cnt++;
      if (m_phase == 2) begin
        chk("frame_pixels", m_shifts, N);
        chk("frame_windows", m_acc, NWIN);
      end
    end
    if (!rst) begin
      case (m_phase)
        0: begin
          if (start) begin
            m_phase  = 1;
            m_reads  = 0;
            m_shifts = 0;
            m_acc    = 0;
          end
        end
        1: begin
          fin = (m_reads == N) && (inflight == 0) && (!ev || bus.out_ready);
          if (exp_sh) begin
            k  = m_shifts;
            ev = in_image(k);
            er = k / IMG_W - HALF;
            ec = k % IMG_W - HALF;
            m_shifts++;
          end else if (acc_now) begin
            ev = 0;
          end
          if (exp_rd) m_reads++;
          if (fin) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    rst_prev = rst;
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input bit rnd, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
      else if (rnd) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
    chk("done_timeout", seen, 1);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    bit got;
    bus.out_ready = 1'b1;
    for (int r = HALF; r <= IMG_H - 1 - HALF; r++)
      for (int c = HALF; c <= IMG_W - 1 - HALF; c++) begin
        exp_r.push_back(r);
        exp_c.push_back(c);
      end
    chk("model_nwin", exp_r.size(), 12);
    chk("model_first_r", exp_r[0], 5);
    chk("model_first_c", exp_c[0], 5);
    chk("model_last_r", exp_r[exp_r.size() - 1], 6);
    chk("model_last_c", exp_c[exp_c.size() - 1], 10);
    chk("model_edge_10_9", int'(in_image(10 * IMG_W + 9)), 0);
    chk("model_edge_10_10", int'(in_image(10 * IMG_W + 10)), 1);
    chk("model_wrap_row", (15 + 1) / IMG_W, 1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_ram_addr", bus.ram_addr, 0);

    // Free-running frame.
    pulse_start();
    chk("first_rd_en", bus.ram_rd_en, 1);
    chk("first_addr", bus.ram_addr, 0);
    @(posedge clk); #1;
    chk("first_shift", bus.shift_en, 1);
    chk("second_addr", bus.ram_addr, 1);
    run_until_done(0, 1000);
    #1;
    chk("busy_falls_with_done", busy, 0);

    // Seven-cycle stall on the first window.
    pulse_start();
    got = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.win_valid) got = 1;
    end
    chk("stall_valid_timeout", got, 1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #2;
      chk("stall_shift", bus.shift_en, 0);
      chk("stall_rd", bus.ram_rd_en, 0);
      chk("stall_row", bus.win_row, 5);
      chk("stall_col", bus.win_col, 5);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    run_until_done(0, 1000);

    // Random backpressure over two frames.
    for (int f = 0; f < 2; f++) begin
      pulse_start();
      run_until_done(1, 3000);
    end

    // start during SCAN is ignored; start in DONE ignored, taken in IDLE.
    pulse_start();
    repeat (20) @(posedge clk);
    pulse_start();
    run_until_done(0, 1000);
    start = 1'b1;
    @(posedge clk); #1;
    chk("done_cycle_start_ignored", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_start_taken", busy, 1);
    run_until_done(0, 1000);

    // Reset around pixel 100, then restart.
    pulse_start();
    got = 0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(posedge clk); #1;
      if (m_shifts >= 100) got = 1;
    end
    chk("pix100_timeout", got, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", bus.ram_addr, 0);
    chk("abort_valid", bus.win_valid, 0);
    repeat (5) @(posedge clk);
    pulse_start();
    chk("restart_addr", bus.ram_addr, 0);
    run_until_done(0, 1000);

    repeat (3) @(posedge clk);
    chk("done_pulses", m_done_cnt, 7);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
